// File: rtl/mac_accum.sv
// Two-stage multiply-accumulate: registers 4x4 operand pairs, multiplies them in
// dadda, sums LEN products into acc. Optional build macro MAC_SAT_EN clamps acc on overflow.

module dadda (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [8:1] p
);
  logic [7:0] a_ext, b_ext;

  assign a_ext = {4'b0000, a};
  assign b_ext = {4'b0000, b};
  assign p     = a_ext * b_ext;
endmodule

module mac_accum #(
  parameter int ACC_W = 12,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);
  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             v1_q, v1_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [8:1]       prod;
  logic [ACC_W:0]   sum;

  dadda u_mul (.a(a_q), .b(b_q), .p(prod));

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign acc       = acc_q;
  assign ovf       = ovf_q;

  assign accept = in_valid && in_ready;
  // Extra top bit captures the carry out of the accumulator.
  assign sum    = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    v1_d    = accept;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    if (accept) begin
      a_d   = a;
      b_d   = b;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (v1_q) begin
      ovf_d = ovf_q | sum[ACC_W];
`ifdef MAC_SAT_EN
      acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end

    // v1 is always clear in HOLD, so the drain never races an add.
    case (state_q)
      ACCUM: if (accept && cnt_q == CNT_W'(LEN - 1)) state_d = FLUSH;
      FLUSH: state_d = HOLD;
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      v1_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v1_q    <= v1_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: main (12,4), overflow (8,2) and LEN=1 instances.

module tb_mac_accum;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // main instance: ACC_W=12, LEN=4
  logic        iv0, ir0, ov0, or0, ovf0;
  logic [3:0]  a0, b0;
  logic [11:0] acc0;
  // overflow instance: ACC_W=8, LEN=2
  logic        iv1, ir1, ov1, or1, ovf1;
  logic [3:0]  a1, b1;
  logic [7:0]  acc1;
  // single-product instance: ACC_W=12, LEN=1
  logic        iv2, ir2, ov2, or2, ovf2;
  logic [3:0]  a2, b2;
  logic [11:0] acc2;

  mac_accum #(.ACC_W(12), .LEN(4)) u_main (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .acc(acc0), .ovf(ovf0));

  mac_accum #(.ACC_W(8), .LEN(2)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .acc(acc1), .ovf(ovf1));

  mac_accum #(.ACC_W(12), .LEN(1)) u_len1 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .acc(acc2), .ovf(ovf2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic feed0(input logic [3:0] x, input logic [3:0] y);
    iv0 = 1'b1; a0 = x; b0 = y;
    step();
  endtask

  task automatic hold0(input string tag, input logic [11:0] exp_acc, input logic exp_ovf);
    chk({tag, "_ov"},  ov0,  1);
    chk({tag, "_ir"},  ir0,  0);
    chk({tag, "_acc"}, acc0, exp_acc);
    chk({tag, "_ovf"}, ovf0, exp_ovf);
  endtask

  initial begin
    logic [7:0] exp_sat;
`ifdef MAC_SAT_EN
    exp_sat = 8'd255;
`else
    exp_sat = 8'd194;
`endif
    rst = 1'b1;
    iv0 = 0; a0 = 0; b0 = 0; or0 = 1;
    iv1 = 0; a1 = 0; b1 = 0; or1 = 1;
    iv2 = 0; a2 = 0; b2 = 0; or2 = 1;

    // reset then idle
    step(); step();
    rst = 1'b0;
    chk("rst_ir",  ir0,  1);
    chk("rst_ov",  ov0,  0);
    chk("rst_acc", acc0, 0);
    chk("rst_ovf", ovf0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", {ir0, ov0, ovf0, acc0}, {3'b100, 12'd0});
    end

    // back-to-back dot product, out_ready=1
    feed0(4'd3, 4'd5);
    chk("b2b_ir_mid", ir0, 1);
    feed0(4'd15, 4'd15);
    feed0(4'd0, 4'd9);
    feed0(4'd7, 4'd2);
    iv0 = 1'b0;
    chk("b2b_flush_ir", ir0, 0);
    chk("b2b_flush_ov", ov0, 0);
    step();
    hold0("b2b", 12'd254, 1'b0);
    step();
    chk("b2b_drain_ir",  ir0,  1);
    chk("b2b_drain_ov",  ov0,  0);
    chk("b2b_drain_acc", acc0, 0);

    // back-pressure: result held while out_ready=0, offered pairs ignored
    or0 = 1'b0;
    feed0(4'd3, 4'd5);
    feed0(4'd15, 4'd15);
    feed0(4'd0, 4'd9);
    feed0(4'd7, 4'd2);
    iv0 = 1'b0;
    step();
    iv0 = 1'b1; a0 = 4'd1; b0 = 4'd1;
    for (int i = 0; i < 6; i++) begin
      hold0("bp", 12'd254, 1'b0);
      step();
    end
    hold0("bp_end", 12'd254, 1'b0);
    iv0 = 1'b0; or0 = 1'b1;
    step();
    chk("bp_drain_ov",  ov0,  0);
    chk("bp_drain_acc", acc0, 0);
    chk("bp_drain_ir",  ir0,  1);

    // mid-operation reset discards partial sum
    feed0(4'd9, 4'd9);
    feed0(4'd9, 4'd9);
    iv0 = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_acc", acc0, 0);
    chk("mrst_ir",  ir0,  1);
    for (int i = 0; i < 4; i++) feed0(4'd1, 4'd1);
    iv0 = 1'b0;
    step();
    hold0("mrst", 12'd4, 1'b0);
    step();
    chk("mrst_drain_ov", ov0, 0);

    // overflow on ACC_W=8, LEN=2
    iv1 = 1'b1; a1 = 4'd15; b1 = 4'd15;
    step();
    step();
    iv1 = 1'b0;
    chk("ovf_flush_ir", ir1, 0);
    step();
    chk("ovf_ov",  ov1,  1);
    chk("ovf_acc", acc1, exp_sat);
    chk("ovf_bit", ovf1, 1);
    step();
    chk("ovf_drain_ovf", ovf1, 0);
    chk("ovf_drain_acc", acc1, 0);
    chk("ovf_drain_ir",  ir1,  1);

    // LEN=1 with bubbles
    iv2 = 1'b1; a2 = 4'd4; b2 = 4'd4;
    step();
    iv2 = 1'b0;
    chk("l1_flush_ir", ir2, 0);
    step();
    chk("l1_r1_ov",  ov2,  1);
    chk("l1_r1_ir",  ir2,  0);
    chk("l1_r1_acc", acc2, 16);
    iv2 = 1'b1; a2 = 4'd2; b2 = 4'd3;
    step();
    chk("l1_drain_ir",  ir2,  1);
    chk("l1_drain_acc", acc2, 0);
    step();
    iv2 = 1'b0;
    chk("l1_flush2_ir", ir2, 0);
    step();
    chk("l1_r2_ov",  ov2,  1);
    chk("l1_r2_acc", acc2, 6);
    step();
    step();
    step();
    chk("l1_no_dup_ov",  ov2,  0);
    chk("l1_no_dup_acc", acc2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
